// File: rtl/dcache_pkg.sv
`default_nettype none
// dcache_pkg: shared constants and refill FSM encoding for the data-cache miss handler.
// Rev 1.0
package dcache_pkg;

  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_BITS    = 5;
  localparam int ADDR_WIDTH     = 32;
  localparam int WORD_BITS      = 32;
  localparam int LINE_BITS      = WORDS_PER_LINE * WORD_BITS;

  localparam logic [ADDR_WIDTH-1:0] LINE_BASE_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_UPDATE    = 2'd3
  } refill_state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_line_buffer.sv
`default_nettype none
// dcache_line_buffer: line-wide register assembled one word at a time, cleared on reset.
// Rev 1.0
module dcache_line_buffer #(
  parameter int WORDS   = 8,
  parameter int WIDTH   = 32,
  parameter int INDEX_W = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [INDEX_W-1:0]       index,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WORDS*WIDTH-1:0]   line
);

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_q <= '0;
      end else if (we && (index == INDEX_W'(w))) begin
        word_q <= wdata;
      end
    end

    assign line[w*WIDTH +: WIDTH] = word_q;
  end

endmodule
`default_nettype wire

// File: rtl/dcache_refill_controller.sv
`default_nettype none
// dcache_refill_controller: stalls the core on a D-cache miss, writes back a dirty victim
// and refills the missing line from data memory one word beat at a time. Rev 1.0
module dcache_refill_controller #(
  parameter int WORDS_PER_LINE = 8,
  parameter int OFFSET_BITS    = 5,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cpu_read_enable,
  input  logic                           cpu_write_enable,
  input  logic [ADDR_WIDTH-1:0]          cpu_address,
  input  logic                           cache_hit,
  input  logic                           victim_dirty,
  input  logic [ADDR_WIDTH-1:0]          victim_address,
  input  logic [WORDS_PER_LINE*32-1:0]   victim_data,
  output logic [WORDS_PER_LINE*32-1:0]   dm_data,
  output logic                           refill_valid,
  output logic                           stall,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic [31:0]                    mem_wdata,
  input  logic                           mem_ready,
  input  logic [31:0]                    mem_rdata
);
  import dcache_pkg::*;

  localparam int LINE_W = WORDS_PER_LINE * WORD_BITS;
  localparam int BEAT_W = $clog2(WORDS_PER_LINE);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [BEAT_W-1:0]     b);
    beat_addr = base + ADDR_WIDTH'({b, 2'b00});
  endfunction

  refill_state_t           state;
  logic [BEAT_W-1:0]       beat;
  logic [BEAT_W-1:0]       next_beat;
  logic [ADDR_WIDTH-1:0]   miss_base;
  logic [ADDR_WIDTH-1:0]   victim_base;
  logic [LINE_W-1:0]       victim_line;
  logic [LINE_W-1:0]       buf_line;
  logic [LINE_W-1:0]       merged_line;
  logic                    miss_now;
  logic                    buf_we;

  assign miss_now  = (cpu_read_enable | cpu_write_enable) & ~cache_hit;
  assign stall     = (state == ST_IDLE) ? miss_now : 1'b1;
  assign next_beat = beat + BEAT_W'(1);
  assign buf_we    = (state == ST_REFILL) & mem_ready;

  // The last read beat lands in the buffer on the same edge that publishes dm_data,
  // so the published line is the buffer with the current beat merged in.
  always_comb begin
    merged_line = buf_line;
    merged_line[int'(beat)*WORD_BITS +: WORD_BITS] = mem_rdata;
  end

  dcache_line_buffer #(
    .WORDS   (WORDS_PER_LINE),
    .WIDTH   (WORD_BITS),
    .INDEX_W (BEAT_W)
  ) u_line_buffer (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .index (beat),
    .wdata (mem_rdata),
    .line  (buf_line)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      beat         <= '0;
      miss_base    <= '0;
      victim_base  <= '0;
      victim_line  <= '0;
      dm_data      <= '0;
      refill_valid <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
    end else begin
      refill_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (miss_now) begin
            miss_base <= cpu_address & BASE_MASK;
            mem_req   <= 1'b1;
            if (victim_dirty) begin
              victim_base <= victim_address & BASE_MASK;
              victim_line <= victim_data;
              state       <= ST_WRITEBACK;
              mem_we      <= 1'b1;
              mem_address <= victim_address & BASE_MASK;
              mem_wdata   <= victim_data[WORD_BITS-1:0];
            end else begin
              state       <= ST_REFILL;
              mem_we      <= 1'b0;
              mem_address <= cpu_address & BASE_MASK;
              mem_wdata   <= '0;
            end
          end
        end

        ST_WRITEBACK: begin
          if (mem_ready) begin
            if (beat == LAST_BEAT) begin
              state       <= ST_REFILL;
              beat        <= '0;
              mem_we      <= 1'b0;
              mem_address <= miss_base;
              mem_wdata   <= '0;
            end else begin
              beat        <= next_beat;
              mem_address <= beat_addr(victim_base, next_beat);
              mem_wdata   <= victim_line[int'(next_beat)*WORD_BITS +: WORD_BITS];
            end
          end
        end

        ST_REFILL: begin
          if (mem_ready) begin
            if (beat == LAST_BEAT) begin
              state        <= ST_UPDATE;
              beat         <= '0;
              mem_req      <= 1'b0;
              mem_address  <= '0;
              dm_data      <= merged_line;
              refill_valid <= 1'b1;
            end else begin
              beat        <= next_beat;
              mem_address <= beat_addr(miss_base, next_beat);
            end
          end
        end

        ST_UPDATE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_refill_controller.sv
`default_nettype none
// tb_dcache_refill_controller: table-driven and randomized checks of the refill controller
// against a line-level memory/transfer model.
module tb_dcache_refill_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_read_enable, cpu_write_enable;
  logic [31:0]  cpu_address;
  logic         cache_hit, victim_dirty;
  logic [31:0]  victim_address;
  logic [255:0] victim_data;
  logic [255:0] dm_data;
  logic         refill_valid, stall, mem_req, mem_we;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_ready = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dcache_refill_controller dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_read_enable  (cpu_read_enable),
    .cpu_write_enable (cpu_write_enable),
    .cpu_address      (cpu_address),
    .cache_hit        (cache_hit),
    .victim_dirty     (victim_dirty),
    .victim_address   (victim_address),
    .victim_data      (victim_data),
    .dm_data          (dm_data),
    .refill_valid     (refill_valid),
    .stall            (stall),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        hit;
    logic        dirty;
    logic [31:0] vaddr;
    logic [31:0] vlo;
    int          wait_n;
    logic        churn;
    int          line_mode;
    int          exp_stall;
    logic [31:0] exp_first;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  bit          hold_valid = 0;
  logic [64:0] held;
  logic [31:0] read_line [8];
  beat_t       obs [$];
  vec_t        tbl [7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] victim_line_of(input logic [31:0] lo);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = lo ^ (32'(k) * 32'h0101_0101);
    return l;
  endfunction

  function automatic logic [64:0] pack(input beat_t b);
    return {b.we, b.addr, (b.we ? b.wdata : 32'h0)};
  endfunction

  task automatic fill_line(input int mode);
    for (int k = 0; k < 8; k++) begin
      case (mode)
        1:       read_line[k] = (k == 0) ? 32'hDEAD_BEEF : 32'h0;
        2:       read_line[k] = 32'h1000 + 32'(k);
        default: read_line[k] = $urandom;
      endcase
    end
  endtask

  task automatic churn_inputs();
    cpu_read_enable  = 1'($urandom_range(0, 1));
    cpu_write_enable = 1'($urandom_range(0, 1));
    cpu_address      = $urandom;
    cache_hit        = 1'($urandom_range(0, 1));
    victim_dirty     = 1'($urandom_range(0, 1));
    victim_address   = $urandom;
    victim_data      = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
  endtask

  // Memory responder: accepts a beat after wait_n idle cycles and serves reads from read_line.
  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt       = 0;
      hold_valid = 0;
      mem_ready  = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
    end else begin
      if (hold_valid)
        check("beat_hold", 256'({mem_we, mem_address, mem_wdata}), 256'(held));
      if (wcnt >= wait_n) begin
        mem_ready  = 1'b1;
        mem_rdata  = read_line[mem_address[4:2]];
        obs.push_back('{mem_we, mem_address, mem_wdata});
        wcnt       = 0;
        hold_valid = 0;
      end else begin
        mem_ready  = 1'b0;
        mem_rdata  = $urandom;
        held       = {mem_we, mem_address, mem_wdata};
        hold_valid = 1;
        wcnt++;
      end
    end
  end

  task automatic run_access(input vec_t v, input bit chk_first);
    beat_t        expq [$];
    logic [255:0] vline, exp_line, got_line;
    logic [31:0]  vb, mb;
    int           stall_cnt;
    bit           done;
    vline = victim_line_of(v.vlo);
    fill_line(v.line_mode);
    for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = read_line[k];
    vb = v.vaddr & 32'hFFFF_FFE0;
    mb = v.addr  & 32'hFFFF_FFE0;
    if (v.dirty)
      for (int k = 0; k < 8; k++) expq.push_back('{1'b1, vb + 32'(4*k), vline[32*k +: 32]});
    for (int k = 0; k < 8; k++) expq.push_back('{1'b0, mb + 32'(4*k), 32'h0});

    @(posedge clk); #1;
    wait_n = v.wait_n;
    obs.delete();
    cpu_read_enable  = v.rd;
    cpu_write_enable = v.wr;
    cpu_address      = v.addr;
    cache_hit        = v.hit;
    victim_dirty     = v.dirty;
    victim_address   = v.vaddr;
    victim_data      = vline;

    if (!((v.rd | v.wr) & ~v.hit)) begin
      repeat (3) begin
        @(negedge clk);
        check("no_miss_quiet", 256'({stall, mem_req, refill_valid}), 256'(0));
      end
      @(posedge clk); #1;
      cache_hit = 1'b1;
      return;
    end

    stall_cnt = 0;
    done      = 0;
    got_line  = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (refill_valid) begin
        done     = 1;
        got_line = dm_data;
      end
      @(posedge clk); #1;
      if (done) begin
        cache_hit    = 1'b1;
        victim_dirty = 1'b0;
      end else if (v.churn) begin
        churn_inputs();
      end
    end
    check("refill_done", 256'(done), 256'(1));
    @(negedge clk);
    check("idle_after", 256'({stall, mem_req, refill_valid}), 256'(0));
    check("stall_cycles", 256'(stall_cnt), 256'(v.exp_stall));
    check("line", got_line, exp_line);
    check("beat_count", 256'(obs.size()), 256'(expq.size()));
    for (int i = 0; i < expq.size() && i < obs.size(); i++)
      check("beat", 256'(pack(obs[i])), 256'(pack(expq[i])));
    if (chk_first && obs.size() > 0)
      check("first_addr", 256'(obs[0].addr), 256'(v.exp_first));
    repeat (2) @(negedge clk);
    check("dm_hold", dm_data, exp_line);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit rv_seen;
    vec_t r;

    //           rd    wr    addr          hit   dirty vaddr         vlo           W  churn mode stall first
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0AA0, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b0, 1,   10,   32'h0000_0AA0};
    tbl[1] = '{1'b1, 1'b0, 32'h0008_0AA0, 1'b0, 1'b1, 32'h0000_0AA0, 32'h12AD_BEEF, 0, 1'b0, 0,   18,   32'h0000_0AA0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0,        32'h0,        2, 1'b0, 2,   26,   32'h0000_4000};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_2000, 32'h5555_AAAA, 0, 1'b0, 0,   0,    32'h0};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_7F3C, 1'b0, 1'b1, 32'h0000_9F17, 32'hCAFE_0000, 1, 1'b1, 0,   34,   32'h0000_9F00};
    tbl[5] = '{1'b0, 1'b1, 32'h1234_567F, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b1, 0,   10,   32'h1234_5660};
    tbl[6] = '{1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0080, 32'h1,        0, 1'b0, 0,   0,    32'h0};

    reset            = 1'b0;
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b0;
    cpu_address      = 32'h0;
    cache_hit        = 1'b1;
    victim_dirty     = 1'b0;
    victim_address   = 32'h0;
    victim_data      = '0;
    fill_line(0);

    repeat (2) @(negedge clk);
    check("reset_dm", dm_data, 256'(0));
    check("reset_ctrl", 256'({refill_valid, mem_req, mem_we, stall, mem_address, mem_wdata}), 256'(0));
    cpu_read_enable = 1'b1;
    cache_hit       = 1'b0;
    #1;
    check("reset_stall_comb", 256'(stall), 256'(1));
    cache_hit = 1'b1;
    @(negedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_access(tbl[i], 1'b1);

    // Reset while refilling beat 4 of a clean miss.
    fill_line(2);
    wait_n = 0;
    obs.delete();
    @(posedge clk); #1;
    cpu_read_enable = 1'b1; cpu_write_enable = 1'b0; cpu_address = 32'h3000;
    cache_hit = 1'b0; victim_dirty = 1'b0;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk); #1;
      if (obs.size() == 4) ok = 1;
    end
    check("rst_mid_reach", 256'(ok), 256'(1));
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("rst_mid_ctrl", 256'({mem_req, mem_we, refill_valid, mem_address}), 256'(0));
    check("rst_mid_dm", dm_data, 256'(0));
    cache_hit = 1'b1;
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (refill_valid) rv_seen = 1;
    end
    check("rst_no_pulse", 256'(rv_seen), 256'(0));
    #1 reset = 1'b1;
    r = '{1'b1, 1'b0, 32'h0000_3000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 2, 10, 32'h0000_3000};
    run_access(r, 1'b1);

    // Core keeps missing after the refill: a fresh miss must start.
    fill_line(0);
    wait_n = 0;
    @(posedge clk); #1;
    cpu_read_enable = 1'b1; cpu_write_enable = 1'b0; cpu_address = 32'h0000_0500;
    cache_hit = 1'b0; victim_dirty = 1'b0;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (refill_valid) ok = 1;
    end
    check("remiss_done", 256'(ok), 256'(1));
    @(negedge clk);
    check("remiss_stall", 256'({stall, mem_req}), 256'(2'b10));
    @(negedge clk);
    check("remiss_req", 256'({mem_req, mem_we, mem_address}), 256'({1'b1, 1'b0, 32'h0000_0500}));
    @(posedge clk); #1;
    reset     = 1'b0;
    cache_hit = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 30; i++) begin
      r.rd        = 1'($urandom_range(0, 1));
      r.wr        = 1'($urandom_range(0, 1));
      r.addr      = $urandom;
      r.hit       = ($urandom_range(0, 3) == 0);
      r.dirty     = 1'($urandom_range(0, 1));
      r.vaddr     = $urandom;
      r.vlo       = $urandom;
      r.wait_n    = int'($urandom_range(0, 3));
      r.churn     = 1'($urandom_range(0, 1));
      r.line_mode = 0;
      r.exp_stall = 2 + (r.dirty ? 16 : 8) * (r.wait_n + 1);
      r.exp_first = (r.dirty ? r.vaddr : r.addr) & 32'hFFFF_FFE0;
      run_access(r, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_refill_controller.md
Name: dcache_refill_controller

Overview:
- Miss handler directly downstream of the data cache, sitting between the cache and data memory.
- On a cache miss it stalls the core and writes back the dirty victim line as 8 word beats.
- It then fetches the missing line as 8 word beats, assembles the 256-bit line, and presents it on dm_data with a one-cycle refill_valid pulse so the cache can update.
- The core's access then retries and hits.

Parameters:
- WORDS_PER_LINE, 8, 32-bit words per cache line.
- OFFSET_BITS, 5, byte-offset bits of a line address.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_read_enable  in  1  core load request.
- cpu_write_enable  in  1  core store request.
- cpu_address  in  32  core byte address.
- cache_hit  in  1  cache hit for cpu_address.
- victim_dirty  in  1  replaced way at this index is dirty.
- victim_address  in  32  line address of the dirty victim.
- victim_data  in  256  victim line contents.
- dm_data  out  256  refilled line to the cache.
- refill_valid  out  1  one-cycle pulse: dm_data is a complete line.
- stall  out  1  freeze core / PC.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_address  out  32  word address of the current beat.
- mem_wdata  out  32  write-beat data.
- mem_ready  in  1  beat accepted/completed this cycle.
- mem_rdata  in  32  read-beat data, valid with mem_ready.

Behaviour:
- Reset (reset low, async): state IDLE, beat counter 0, line buffer 0.
  - Outputs: dm_data 0, refill_valid 0, mem_req 0, mem_we 0, mem_address 0, mem_wdata 0.
  - stall follows its combinational rule.
  - Reset mid-transfer aborts the transfer immediately; no partial line is ever pulsed.
- miss_now = (cpu_read_enable | cpu_write_enable) & ~cache_hit. Both enables high counts as one access.
- stall = miss_now while in IDLE; stall = 1 in every other state. Combinational, so the core stalls in the miss cycle itself.
- States:
  - IDLE:
    - On miss_now, latch miss_base = {cpu_address[31:5], 5'b0}.
    - If victim_dirty, also latch victim_address (low 5 bits forced 0) and victim_data, and go to WRITEBACK.
    - Otherwise go to REFILL.
    - Counter cleared.
  - WRITEBACK:
    - mem_req=1, mem_we=1, mem_address = victim_base + 4*k, mem_wdata = victim_data[32k+31:32k].
    - On a rising edge with mem_ready=1, k increments.
    - At k=7 with mem_ready=1, go to REFILL with k=0.
  - REFILL:
    - mem_req=1, mem_we=0, mem_address = miss_base + 4*k.
    - On mem_ready=1, buffer word k <= mem_rdata.
    - At k=7 with mem_ready=1, go to UPDATE.
  - UPDATE (1 cycle): refill_valid=1, dm_data = assembled line, mem_req=0. Next state IDLE.
- Word order: word 0 (lowest address) occupies dm_data[31:0].
- dm_data holds its value after UPDATE until the next refill overwrites it.
- Memory handshake:
  - mem_req, mem_we, mem_address and mem_wdata stay stable until the mem_ready cycle.
  - The next beat is presented the following cycle; mem_req stays high across beats.
  - mem_ready may hold high for back-to-back beats, giving a minimum 8 cycles per phase.
  - mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory, counted from the miss cycle: clean miss takes 1 + 8 + 1 = 10 stall cycles; dirty miss takes 18.
  - First mem_req is asserted in the cycle after the miss.
- During a transfer, changes on the cpu_*, cache_hit and victim_* inputs are ignored (latched copies are used).
- Returning to IDLE: the cycle after UPDATE, the cache hits, so stall drops to 0.
  - If the core still misses (cache_hit=0), a new miss starts; there is no lockup.
- Beat counter is 3 bits, wraps only via the state transition; k never exceeds 7.

Decomposition:
- Shared package dcache_pkg: state encoding (IDLE, WRITEBACK, REFILL, UPDATE), LINE_BITS=256, WORDS_PER_LINE, OFFSET_BITS, line-base mask constant.
- One natural sub-module: dcache_line_buffer, a 256-bit register with an indexed 32-bit word write and clear on reset.

Test Plan:
- Clean read miss: cpu_address=0x00000AA0, cache_hit=0, victim_dirty=0, memory returns 0xDEADBEEF at word 0 and 0 elsewhere, zero-wait -> mem reads at 0xAA0..0xABC, then refill_valid pulses once with dm_data[31:0]=0xDEADBEEF; stall high exactly 10 cycles.
- Dirty miss: victim_address=0x00000AA0, victim_data low word 0x12ADBEEF, miss at 0x00080AA0 -> 8 write beats at 0xAA0..0xABC (first mem_wdata=0x12ADBEEF), then 8 read beats at 0x80AA0..0x80ABC; stall 18 cycles.
- Wait states: mem_ready high only every 3rd cycle -> address and data held stable across waits; line assembled correctly (word k = 0x1000+k); no extra beats.
- Hit path: cache_hit=1 with cpu_read_enable=1 -> stall=0, mem_req never asserted.
- Reset mid-REFILL at beat 4 -> mem_req=0 and dm_data=0 immediately; no refill_valid pulse; next miss restarts at beat 0.
- Input churn during a transfer: cpu_address and victim_* toggled every cycle -> beat addresses still follow the latched miss_base and victim_base.
